tone_seq_ctrl: RTL and testbench
================================

TONE_SEQ_CTRL -- requirements
Module: tone_seq_ctrl

Interface
REQ-001 SHALL have parameter REST_PERIOD, default 32'd49999, meaning the timer period programmed for rest notes (note_period==0).
REQ-002 SHALL have ports `clk`, input, 1, the single clock; one clock; reset is synchronous and active-low.
REQ-003 SHALL have port `reset_n`, input, 1, synchronous active-low reset, sampled on rising `clk`.
REQ-004 SHALL have `note_valid` input 1 and `note_ready` output 1: note request handshake, transfer on a cycle with both high.
REQ-005 SHALL have `note_period` input 32 (timer period per half-wave) and `note_count` input 16 (number of half-waves), both captured at transfer.
REQ-006 SHALL have `stop_req` input 1, which aborts the current note.
REQ-007 SHALL have `tmr_address` output 3, `tmr_chipselect` output 1, `tmr_write_n` output 1 and `tmr_writedata` output 16, forming the Avalon write port to the interval timer (0 status, 1 control, 2 period_l, 3 period_h).
REQ-008 SHALL have `tmr_irq` input 1, the timer timeout interrupt.
REQ-009 SHALL have outputs `tone_out` 1 (square wave), `busy` 1 (note in progress) and `note_done` 1 (one-cycle pulse on normal completion).

Function
REQ-010 SHALL implement states IDLE, W_STOP, W_PL, W_PH, W_CTRL, WAIT, W_CLR, W_END.
REQ-011 IDLE: note_ready=1, busy=0; on transfer with note_count==0, SHALL pulse note_done next cycle, make no timer access and stay in IDLE.
REQ-012 IDLE: on transfer with note_count!=0, SHALL capture period and count, then go to W_STOP.
REQ-013 Each W_* state SHALL last exactly one cycle with chipselect=1 and write_n=0; all other states SHALL drive chipselect=0, write_n=1, address=0, writedata=0.
REQ-014 W_STOP SHALL write control 16'h0008; W_PL and W_PH SHALL write period[15:0] and period[31:16] (REST_PERIOD when captured period==0); W_CTRL SHALL write control 16'h0007 (ITO|CONT|START).
REQ-015 The first timer write SHALL occur 1 cycle after transfer; W_CTRL SHALL occur at transfer+4.
REQ-016 WAIT: on tmr_irq=1, SHALL go to W_CLR, which writes status 16'h0000.
REQ-017 In W_CLR, a non-rest note SHALL toggle tone_out, and a rest SHALL hold tone_out at 0.
REQ-018 In W_CLR, the remaining count SHALL be decremented; if it reaches 0, next state SHALL be W_END, else WAIT.
REQ-019 Count arithmetic SHALL be 16-bit unsigned with no wrap; 16'hFFFF SHALL yield 65535 half-waves.
REQ-020 W_END SHALL write control 16'h0008, force tone_out=0, pulse note_done in the following cycle and return to IDLE.
REQ-021 tmr_irq seen in the cycle directly after W_CLR SHALL be treated as a new timeout only if still high; the timer clears irq on the W_CLR edge.
REQ-022 stop_req in any non-IDLE state SHALL go to W_END next cycle, with tone_out=0, no note_done pulse, and pending irq ignored.
REQ-023 stop_req and tmr_irq both high in WAIT: stop_req SHALL win.
REQ-024 stop_req in IDLE SHALL be ignored, and note_valid outside IDLE SHALL NOT be accepted.
REQ-025 busy SHALL be 1 in all states except IDLE.

Reset
REQ-026 On reset_n=0 at a clock edge, state SHALL be IDLE, with tone_out=0, note_done=0, busy=0, note_ready=0 during reset, chipselect=0, write_n=1, address=0 and writedata=0.
REQ-027 Reset mid-note SHALL abandon the note with no END write; the next note's W_STOP re-establishes the timer state.

Configuration
REQ-028 With TONE_SEQ_GAP_EN defined, reaching count 0 in W_CLR SHALL enter GAP: one extra timeout (WAIT on irq, then status clear) with tone_out held 0, then W_END. Without the macro, there SHALL be no GAP state and W_CLR goes directly to W_END.

Verification
REQ-029 period=100, count=4, timer model fires irq every 101 cycles -> writes at cycles 1..4 (0x8, 100, 0, 0x7), tone toggles 4 times, ends at 0, END write 0x8, one note_done.
REQ-030 period=0, count=2 -> W_PL/W_PH write 49999/0, tone_out stays 0, note_done pulses once.
REQ-031 count=0 -> no chipselect at all, note_done at transfer+1, note_ready stays 1.
REQ-032 stop_req in the same cycle as irq in WAIT, count=5 -> next cycle W_END writes 0x8, no status write, no note_done, tone_out=0.
REQ-033 reset_n low for 1 cycle during WAIT -> next cycle all outputs at REQ-026 values; next note starts with W_STOP.
REQ-034 With TONE_SEQ_GAP_EN, count=2 -> 3 status clears, 2 toggles, note_done after the third timeout.

Source files
------------

// File: rtl/tone_seq_ctrl.sv
// tone_seq_ctrl: plays one note at a time by programming an Avalon interval
// timer, toggling tone_out on each timeout and counting half-waves.
// Optional feature: define TONE_SEQ_GAP_EN to add a silent gap of one extra
// timeout after the last half-wave before the note is closed.
module tone_seq_ctrl #(
    parameter logic [31:0] REST_PERIOD = 32'd49999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [31:0] note_period,
    input  logic [15:0] note_count,
    input  logic        stop_req,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic        tmr_irq,
    output logic        tone_out,
    output logic        busy,
    output logic        note_done
);

    localparam logic [2:0]  A_STATUS   = 3'd0;
    localparam logic [2:0]  A_CONTROL  = 3'd1;
    localparam logic [2:0]  A_PERIOD_L = 3'd2;
    localparam logic [2:0]  A_PERIOD_H = 3'd3;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;
    localparam logic [15:0] CTRL_RUN   = 16'h0007;

    typedef enum logic [3:0] {
        IDLE, W_STOP, W_PL, W_PH, W_CTRL, WAIT, W_CLR, W_END
`ifdef TONE_SEQ_GAP_EN
        , G_WAIT, G_CLR
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [15:0] count_q, count_d;
    logic        done_pend_q, done_pend_d;
    logic        tone_q, tone_d;
    logic        note_done_q, note_done_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        cs_q, cs_d;
    logic        wrn_q, wrn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;

    logic        xfer;
    logic        rest;
    logic [31:0] eff_period;

    assign xfer       = (state_q == IDLE) && ready_q && note_valid;
    assign rest       = (period_q == 32'd0);
    assign eff_period = rest ? REST_PERIOD : period_q;

    // Next-state, note bookkeeping and the registered output values that go
    // with the state being entered.
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        count_d     = count_q;
        done_pend_d = done_pend_q;
        tone_d      = tone_q;
        note_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (note_count == 16'd0) begin
                        note_done_d = 1'b1;
                    end else begin
                        period_d    = note_period;
                        count_d     = note_count;
                        done_pend_d = 1'b0;
                        state_d     = W_STOP;
                    end
                end
            end
            W_STOP: state_d = W_PL;
            W_PL:   state_d = W_PH;
            W_PH:   state_d = W_CTRL;
            W_CTRL: state_d = WAIT;
            WAIT: begin
                if (tmr_irq) begin
                    state_d = W_CLR;
                    tone_d  = rest ? 1'b0 : ~tone_q;
                end
            end
            W_CLR: begin
                count_d = count_q - 16'd1;
                if (count_q == 16'd1) begin
                    tone_d = 1'b0;
`ifdef TONE_SEQ_GAP_EN
                    state_d = G_WAIT;
`else
                    state_d     = W_END;
                    done_pend_d = 1'b1;
`endif
                end else begin
                    state_d = WAIT;
                end
            end
`ifdef TONE_SEQ_GAP_EN
            G_WAIT: begin
                if (tmr_irq) begin
                    state_d = G_CLR;
                end
            end
            G_CLR: begin
                state_d     = W_END;
                done_pend_d = 1'b1;
            end
`endif
            W_END: begin
                state_d     = IDLE;
                note_done_d = done_pend_q && !stop_req;
                done_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // An abort overrides everything, including a timeout seen this cycle.
        if (stop_req && (state_q != IDLE) && (state_q != W_END)) begin
            state_d     = W_END;
            tone_d      = 1'b0;
            done_pend_d = 1'b0;
        end
    end

    // Bus write and status outputs decoded from the state being entered, so
    // they appear registered in the same cycle as that state.
    always_comb begin
        cs_d    = 1'b0;
        wrn_d   = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'd0;
        case (state_d)
            W_STOP, W_END: begin
                cs_d    = 1'b1;
                wrn_d   = 1'b0;
                addr_d  = A_CONTROL;
                wdata_d = CTRL_STOP;
            end
            W_PL: begin
                cs_d    = 1'b1;
                wrn_d   = 1'b0;
                addr_d  = A_PERIOD_L;
                wdata_d = eff_period[15:0];
            end
            W_PH: begin
                cs_d    = 1'b1;
                wrn_d   = 1'b0;
                addr_d  = A_PERIOD_H;
                wdata_d = eff_period[31:16];
            end
            W_CTRL: begin
                cs_d    = 1'b1;
                wrn_d   = 1'b0;
                addr_d  = A_CONTROL;
                wdata_d = CTRL_RUN;
            end
`ifdef TONE_SEQ_GAP_EN
            W_CLR, G_CLR: begin
`else
            W_CLR: begin
`endif
                cs_d    = 1'b1;
                wrn_d   = 1'b0;
                addr_d  = A_STATUS;
                wdata_d = 16'd0;
            end
            default: begin
                cs_d    = 1'b0;
                wrn_d   = 1'b1;
                addr_d  = 3'd0;
                wdata_d = 16'd0;
            end
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State and registered outputs; the captured note data needs no reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            done_pend_q <= 1'b0;
            tone_q      <= 1'b0;
            note_done_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            cs_q        <= 1'b0;
            wrn_q       <= 1'b1;
            addr_q      <= 3'd0;
            wdata_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            done_pend_q <= done_pend_d;
            tone_q      <= tone_d;
            note_done_q <= note_done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            cs_q        <= cs_d;
            wrn_q       <= wrn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
        period_q <= period_d;
        count_q  <= count_d;
    end

    assign note_ready     = ready_q;
    assign busy           = busy_q;
    assign note_done      = note_done_q;
    assign tone_out       = tone_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wrn_q;
    assign tmr_address    = addr_q;
    assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_tone_seq_ctrl.sv
// Scoreboard bench for tone_seq_ctrl: an interval-timer model answers the
// bus, a note-level reference model queues the expected timer writes and
// note_done pulses, and a monitor pops and compares them as they appear.
`timescale 1ns/1ps
module tb_tone_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        note_valid = 1'b0;
    logic        note_ready;
    logic [31:0] note_period = 32'd0;
    logic [15:0] note_count = 16'd0;
    logic        stop_req = 1'b0;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq = 1'b0;
    logic        tone_out;
    logic        busy;
    logic        note_done;

    always #5 clk = ~clk;

    tone_seq_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .note_valid(note_valid), .note_ready(note_ready),
        .note_period(note_period), .note_count(note_count),
        .stop_req(stop_req),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
        .tmr_irq(tmr_irq),
        .tone_out(tone_out), .busy(busy), .note_done(note_done)
    );

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        tone;
        int          rel;     // cycles after transfer, or -1 when not fixed
        bit          is_end;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];          // expected cycle of note_done, -1 = END write + 1
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  xfer_cyc = 0;
    int  last_end_cyc = -100;
    int  clr_cnt = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic wr_t mk(input logic [2:0] a, input logic [15:0] d,
                               input logic t, input int rel, input bit e);
        wr_t r;
        r.addr = a; r.data = d; r.tone = t; r.rel = rel; r.is_end = e;
        return r;
    endfunction

    // Interval timer model; long periods are time-compressed to keep runs short.
    logic [15:0] tm_pl = 16'd0;
    logic [15:0] tm_ph = 16'd0;
    logic        tm_run = 1'b0;
    int          tm_left = 0;

    function automatic int tm_interval(input logic [31:0] p);
        return (p > 32'd500) ? 37 : int'(p) + 1;
    endfunction

    // Timer register writes, countdown and timeout flag.
    always @(posedge clk) begin
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: tmr_irq <= 1'b0;
                3'd1: begin
                    if (tmr_writedata[3]) tm_run <= 1'b0;
                    else if (tmr_writedata[2]) begin
                        tm_run  <= 1'b1;
                        tm_left <= tm_interval({tm_ph, tm_pl}) - 1;
                    end
                end
                3'd2: tm_pl <= tmr_writedata;
                3'd3: tm_ph <= tmr_writedata;
                default: ;
            endcase
        end
        if (tm_run) begin
            if (tm_left == 0) begin
                tmr_irq <= 1'b1;
                tm_left <= tm_interval({tm_ph, tm_pl}) - 1;
            end else begin
                tm_left <= tm_left - 1;
            end
        end
    end

    // Reference model: the timer writes and completion a note must produce.
    task automatic push_note(input logic [31:0] per, input logic [15:0] cnt,
                             input int stop_k, input bit rst_abort);
        logic [31:0] eff;
        int n_clr;
        logic t;
        eff = (per == 32'd0) ? 32'd49999 : per;
        if (cnt == 16'd0) begin
            done_q.push_back(xfer_cyc + 1);
            return;
        end
        wr_q.push_back(mk(3'd1, 16'h0008, 1'b0, 1, 1'b0));
        wr_q.push_back(mk(3'd2, eff[15:0], 1'b0, 2, 1'b0));
        wr_q.push_back(mk(3'd3, eff[31:16], 1'b0, 3, 1'b0));
        wr_q.push_back(mk(3'd1, 16'h0007, 1'b0, 4, 1'b0));
        n_clr = (stop_k >= 0) ? stop_k : int'(cnt);
        for (int i = 1; i <= n_clr; i++) begin
            t = (per == 32'd0) ? 1'b0 : ((i % 2) == 1);
            wr_q.push_back(mk(3'd0, 16'h0000, t, -1, 1'b0));
        end
`ifdef TONE_SEQ_GAP_EN
        if (stop_k < 0) wr_q.push_back(mk(3'd0, 16'h0000, 1'b0, -1, 1'b0));
`endif
        if (!rst_abort) wr_q.push_back(mk(3'd1, 16'h0008, 1'b0, -1, 1'b1));
        if (stop_k < 0 && !rst_abort) done_q.push_back(-1);
    endtask

    // Monitor: compare every bus write and note_done pulse against the queues.
    always @(negedge clk) begin : mon
        wr_t e;
        int  ed;
        if (mon_en) begin
            if (tmr_chipselect) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write, cycle %0d",
                             tmr_address, tmr_writedata, cyc);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_write_n", 32'(tmr_write_n), 32'd0);
                    chk("wr_addr", 32'(tmr_address), 32'(e.addr));
                    chk("wr_data", 32'(tmr_writedata), 32'(e.data));
                    chk("wr_tone", 32'(tone_out), 32'(e.tone));
                    if (e.rel >= 0) chk("wr_latency", 32'(cyc - xfer_cyc), 32'(e.rel));
                    if (e.addr == 3'd0) clr_cnt++;
                    if (e.is_end) last_end_cyc = cyc;
                end
            end else begin
                chk("bus_idle", 32'({tmr_write_n, tmr_address, tmr_writedata}),
                    32'({1'b1, 3'd0, 16'd0}));
            end
            if (note_done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got note_done=1, expected 0, cycle %0d", cyc);
                end else begin
                    ed = done_q.pop_front();
                    if (ed < 0) chk("done_after_end", 32'(cyc), 32'(last_end_cyc + 1));
                    else        chk("done_latency", 32'(cyc), 32'(ed));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tone"}, 32'(tone_out), 32'd0);
        chk({tag, "_done"}, 32'(note_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(note_ready), 32'd0);
        chk({tag, "_cs"}, 32'(tmr_chipselect), 32'd0);
        chk({tag, "_wrn"}, 32'(tmr_write_n), 32'd1);
        chk({tag, "_addr"}, 32'(tmr_address), 32'd0);
        chk({tag, "_data"}, 32'(tmr_writedata), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(busy == 1'b0 && wr_q.size() == 0 && done_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL note_timeout: got %0d writes and %0d dones outstanding, expected 0",
                     wr_q.size(), done_q.size());
            wr_q.delete();
            done_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // One note: handshake, junk offers while busy, optional abort, completion.
    task automatic send_note(input logic [31:0] per, input logic [15:0] cnt,
                             input int stop_k, input bit rst_abort);
        int n;
        @(negedge clk);
        chk("ready_in_idle", 32'(note_ready), 32'd1);
        note_valid  = 1'b1;
        note_period = per;
        note_count  = cnt;
        xfer_cyc    = cyc;
        clr_cnt     = 0;
        push_note(per, cnt, stop_k, rst_abort);
        @(negedge clk);
        if (cnt == 16'd0) begin
            note_valid = 1'b0;
            chk("ready_after_zero", 32'(note_ready), 32'd1);
            chk("busy_after_zero", 32'(busy), 32'd0);
        end else begin
            note_period = $urandom;
            note_count  = 16'($urandom);
            repeat (3) @(negedge clk);
            note_valid = 1'b0;
        end
        if (stop_k >= 0) begin
            n = 0;
            while (!(clr_cnt == stop_k && tmr_irq && !tmr_chipselect) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 5000) begin
                checks++; errors++;
                $display("FAIL abort_window: got no timeout after %0d clears, expected one", clr_cnt);
            end
            if (!rst_abort) begin
                stop_req = 1'b1;
                @(negedge clk);
                stop_req = 1'b0;
            end else begin
                reset_n = 1'b0;
                @(posedge clk);
                #1;
                check_reset_outputs("midnote_rst");
                @(negedge clk);
                reset_n = 1'b1;
                chk("writes_left_after_rst", 32'(wr_q.size()), 32'd0);
                chk("dones_left_after_rst", 32'(done_q.size()), 32'd0);
            end
        end
        wait_idle(20000);
    endtask

    initial begin
        logic [31:0] per;
        logic [15:0] cnt;
        int unsigned r;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);

        // stop_req while idle has no effect
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        chk("idle_stop_ready", 32'(note_ready), 32'd1);
        chk("idle_stop_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("idle_stop_cs", 32'(tmr_chipselect), 32'd0);

        send_note(32'd100, 16'd4, -1, 1'b0);
        send_note(32'd0, 16'd2, -1, 1'b0);
        send_note(32'd55, 16'd0, -1, 1'b0);
        send_note(32'd20, 16'd5, 2, 1'b0);
        send_note(32'd30, 16'd5, 1, 1'b1);
        send_note(32'd30, 16'd3, -1, 1'b0);
        send_note(32'd12, 16'hFFFF, 3, 1'b0);
        send_note(32'd9, 16'd1, -1, 1'b0);

        for (int k = 0; k < 14; k++) begin
            per = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(8, 60));
            cnt = 16'($urandom_range(0, 6));
            r   = $urandom_range(0, 9);
            if (cnt != 16'd0 && r < 2)
                send_note(per, cnt, int'($urandom_range(0, int'(cnt) - 1)), 1'b0);
            else if (cnt != 16'd0 && r == 2)
                send_note(per, cnt, int'($urandom_range(0, int'(cnt) - 1)), 1'b1);
            else
                send_note(per, cnt, -1, 1'b0);
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
